// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder peripheral.
//  - Register offsets decoded from addr[3:2]
//  - STAT register bit positions and a helper that packs the STAT word
//  - Frame FSM state encoding
package spi_slave_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;

    localparam int unsigned STAT_RX_VALID = 0;
    localparam int unsigned STAT_TX_EMPTY = 1;
    localparam int unsigned STAT_OVERRUN  = 2;
    localparam int unsigned STAT_BUSY     = 3;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_t;

    // Build the 32-bit STAT read value from the individual flags.
    function automatic logic [31:0] pack_stat(input logic busy,
                                              input logic overrun,
                                              input logic tx_empty,
                                              input logic rx_valid);
        logic [31:0] s;
        s                = 32'd0;
        s[STAT_RX_VALID] = rx_valid;
        s[STAT_TX_EMPTY] = tx_empty;
        s[STAT_OVERRUN]  = overrun;
        s[STAT_BUSY]     = busy;
        return s;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with edge pulses.
//  clk, resetn : system clock, synchronous active-low reset
//  d_in        : asynchronous input pin
//  rise / fall : one-cycle pulses when the synchronized value changes
// RESET_VAL should match the pin's idle level so that leaving reset does
// not fabricate an edge.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;
    logic                   lvl_s;

    assign lvl_s = sync_q[SYNC_STAGES-1];

    // Next values: shift the pin in, keep one extra delayed copy for edges.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
        dly_d  = lvl_s;
    end

    // Synchronizer chain and delayed copy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign rise = lvl_s & ~dly_q;
    assign fall = ~lvl_s & dly_q;

endmodule

// File: rtl/spi_slave_periph.sv
// Memory-mapped SPI responder (target side) on a valid/ready CPU bus.
// sclk/cs_n/mosi are oversampled in the clk domain; one byte is shifted per
// frame slot, MSB first. RX and TX are double-buffered; overrun is flagged.
// Ports:
//  clk, resetn         : system clock, synchronous active-low reset
//  valid/ready         : bus handshake, ready is a one-cycle acknowledge
//  addr/wstrb/wdata    : request (addr[3:2] decoded, any wstrb bit = write)
//  rdata               : read data, valid while ready=1
//  sclk/cs_n/mosi      : asynchronous SPI inputs from the external master
//  miso                : serial data out, 0 while the frame is idle
// Registers: 0x0 DATA (rd rx byte / wr tx byte), 0x4 STAT
//  {busy, overrun, tx_empty, rx_valid}; writing STAT bit 2 clears overrun.
module spi_slave_periph
    import spi_slave_pkg::*;
#(
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso
);

    frame_state_t state_q, state_d;
    logic busy_s;

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        miso_q, miso_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  tx_buf_q, tx_buf_d;
    logic        tx_empty_q, tx_empty_d;
    logic        overrun_q, overrun_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
    logic lead_s, trail_s, sample_s, shift_s;
    logic mosi_s;
    logic bus_rd_s, bus_wr_s;
    logic byte_done_s, load_s;
    logic [7:0] rx_byte_s, load_val_s;
    logic unused_ok_s;

    assign unused_ok_s = ^{addr[31:4], addr[1:0], wdata[31:8]};

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (CPOL != 0)
    ) u_sclk_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_in   (sclk),
        .rise   (sclk_rise_s),
        .fall   (sclk_fall_s)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_in   (cs_n),
        .rise   (cs_rise_s),
        .fall   (cs_fall_s)
    );

    // mosi only needs a level; same depth keeps it aligned with the sclk edges.
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Map sclk edges onto sample/shift events for this CPOL/CPHA build.
    always_comb begin
        lead_s   = (CPOL == 0) ? sclk_rise_s : sclk_fall_s;
        trail_s  = (CPOL == 0) ? sclk_fall_s : sclk_rise_s;
        sample_s = (CPHA == 0) ? lead_s : trail_s;
        shift_s  = (CPHA == 0) ? trail_s : lead_s;
    end

    // Frame FSM: state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM: next state from synchronized chip-select edges.
    always_comb begin
        case (state_q)
            IDLE:    state_d = cs_fall_s ? ACTIVE : IDLE;
            ACTIVE:  state_d = cs_rise_s ? IDLE : ACTIVE;
            default: state_d = IDLE;
        endcase
    end

    // Frame FSM: outputs.
    always_comb begin
        case (state_q)
            ACTIVE:  busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Datapath next-state: shifters, buffers, flags and bus response.
    always_comb begin
        ready_d     = valid & ~ready_q;
        rdata_d     = 32'd0;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        tx_buf_d    = tx_buf_q;
        tx_empty_d  = tx_empty_q;
        overrun_d   = overrun_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        bus_rd_s    = ready_d & ~(|wstrb);
        bus_wr_s    = ready_d & (|wstrb);
        byte_done_s = 1'b0;
        load_s      = 1'b0;
        rx_byte_s   = {rx_shift_q[6:0], mosi_s};
        load_val_s  = tx_empty_q ? 8'h00 : tx_buf_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d  = 3'd0;
                rx_shift_d = 8'd0;
                miso_d     = 1'b0;
                load_s     = cs_fall_s;
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    // Frame aborted or ended: drop any partial byte.
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 8'd0;
                    miso_d     = 1'b0;
                end else if (sample_s) begin
                    rx_shift_d  = rx_byte_s;
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    byte_done_s = (bit_cnt_q == 3'd7);
                    load_s      = (bit_cnt_q == 3'd7);
                end else if (shift_s) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end else begin
                        // Byte boundary. CPHA=1 presents the MSB of the freshly
                        // loaded byte here; CPHA=0 already presented it at load
                        // time, so the trailing edge after the 8th sample is idle.
                        miso_d = (CPHA != 0) ? tx_shift_q[7] : miso_q;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            default: begin
                bit_cnt_d = 3'd0;
                miso_d    = 1'b0;
            end
        endcase

        if (load_s) begin
            tx_shift_d = load_val_s;
            tx_empty_d = 1'b1;
            miso_d     = (CPHA == 0) ? load_val_s[7] : miso_d;
        end else begin
            tx_shift_d = tx_shift_d;
        end

        // Bus side effects come after the load so that a TX write wins.
        if (bus_rd_s) begin
            case (addr[3:2])
                REG_DATA: begin
                    rdata_d    = {24'd0, rx_data_q};
                    rx_valid_d = 1'b0;
                end
                REG_STAT: rdata_d = pack_stat(busy_s, overrun_q, tx_empty_q, rx_valid_q);
                default:  rdata_d = 32'd0;
            endcase
        end else if (bus_wr_s) begin
            case (addr[3:2])
                REG_DATA: begin
                    tx_buf_d   = wdata[7:0];
                    tx_empty_d = 1'b0;
                end
                REG_STAT: overrun_d = wdata[2] ? 1'b0 : overrun_q;
                default:  tx_buf_d = tx_buf_q;
            endcase
        end else begin
            rdata_d = 32'd0;
        end

        // Byte completion last: set of rx_valid/overrun beats a clear.
        if (byte_done_s) begin
            rx_data_d  = rx_byte_s;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q ? 1'b1 : overrun_d;
        end else begin
            rx_data_d = rx_data_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q     <= 1'b0;
            rdata_q     <= 32'd0;
            miso_q      <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            tx_buf_q    <= 8'd0;
            tx_empty_q  <= 1'b1;
            overrun_q   <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'd0;
            tx_shift_q  <= 8'd0;
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_buf_q    <= tx_buf_d;
            tx_empty_q  <= tx_empty_d;
            overrun_q   <= overrun_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign miso  = miso_q;

endmodule

// File: tb/tb_spi_slave_periph.sv
// Bench for spi_slave_periph: all four CPOL/CPHA builds run side by side on a
// shared bus and a shared SPI master (sclk = clk/8). A register-level model of
// the peripheral predicts every read and every byte shifted out on miso.
module tb_spi_slave_periph;

    logic        clk;
    logic        resetn;
    logic [3:0]  valid_v;
    logic [3:0]  ready_v;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata_v [4];
    logic [1:0]  sclk_p;   // [0] CPOL=0 wire, [1] CPOL=1 wire
    logic        cs_n;
    logic [1:0]  mosi_h;   // [0] changes at trailing edge, [1] at leading edge
    logic [3:0]  miso_v;

    int n_assert;
    int n_fail;

    // reference model of the programmer-visible state
    logic [7:0] m_rx_data;
    logic       m_rx_valid;
    logic [7:0] m_tx_buf;
    logic       m_tx_empty;
    logic       m_overrun;

    logic [7:0]  mosi_bytes [4];
    logic [31:0] rd_cap [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_periph #(
            .CPOL        (g / 2),
            .CPHA        (g % 2),
            .SYNC_STAGES (2)
        ) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .valid  (valid_v[g]),
            .ready  (ready_v[g]),
            .addr   (addr),
            .wstrb  (wstrb),
            .wdata  (wdata),
            .rdata  (rdata_v[g]),
            .sclk   (sclk_p[g / 2]),
            .cs_n   (cs_n),
            .mosi   (mosi_h[g % 2]),
            .miso   (miso_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_stat(input logic busy);
        return {28'd0, busy, m_overrun, m_tx_empty, m_rx_valid};
    endfunction

    task automatic m_reset();
        m_rx_data = 8'd0; m_rx_valid = 1'b0; m_tx_buf = 8'd0;
        m_tx_empty = 1'b1; m_overrun = 1'b0;
    endtask

    task automatic m_load(output logic [7:0] v);
        v = m_tx_empty ? 8'h00 : m_tx_buf;
        m_tx_empty = 1'b1;
    endtask

    task automatic m_byte_done(input logic [7:0] b);
        if (m_rx_valid) m_overrun = 1'b1;
        m_rx_valid = 1'b1;
        m_rx_data  = b;
    endtask

    // One bus transaction on all four DUTs; results land in rd_cap.
    task automatic bus(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
        bit got;
        got = 1'b0;
        addr = a; wstrb = ws; wdata = wd; valid_v = 4'hF;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1);
            if (ready_v == 4'hF) got = 1'b1;
        end
        check("bus_ready", {28'd0, ready_v}, 32'hF);
        for (int g = 0; g < 4; g++) rd_cap[g] = rdata_v[g];
        valid_v = 4'h0; wstrb = 4'h0;
        tick(1);
    endtask

    task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus(a, 4'h0, 32'd0);
        for (int g = 0; g < 4; g++) check($sformatf("%s[%0d]", tag, g), rd_cap[g], exp);
    endtask

    task automatic wr_data(input logic [7:0] v);
        bus(32'h0, 4'hF, {24'd0, v});
        m_tx_buf = v; m_tx_empty = 1'b0;
    endtask

    // DATA read timed to land in the same cycle the masked DUTs finish a byte.
    task automatic coinc_read(input logic [3:0] mask);
        tick(2);
        addr = 32'h0; wstrb = 4'h0; valid_v = mask;
        tick(1);
        check("coinc_ready", {28'd0, ready_v & mask}, {28'd0, mask});
        for (int g = 0; g < 4; g++)
            if (mask[g]) check($sformatf("coinc_old_byte[%0d]", g), rdata_v[g], {24'd0, m_rx_data});
        valid_v = 4'h0;
        tick(1);
    endtask

    // SPI master: nbits bits from mosi_bytes, checking each full byte on miso.
    task automatic spi_frame(input int nbits, input bit end_cs, input bit coinc);
        logic [7:0] exp_tx;
        logic [7:0] cap [4];
        int bi;
        int k;
        m_load(exp_tx);
        cs_n = 1'b0;
        mosi_h[0] = mosi_bytes[0][7];
        tick(4);
        for (int b = 0; b < nbits; b++) begin
            bi = b / 8;
            k  = 7 - (b % 8);
            cap[0][k] = miso_v[0];
            cap[2][k] = miso_v[2];
            sclk_p    = 2'b01;
            mosi_h[1] = mosi_bytes[bi][k];
            if (coinc && k == 0) coinc_read(4'b0101); else tick(4);
            cap[1][k] = miso_v[1];
            cap[3][k] = miso_v[3];
            sclk_p    = 2'b10;
            if (b + 1 < nbits) mosi_h[0] = mosi_bytes[(b + 1) / 8][7 - ((b + 1) % 8)];
            if (coinc && k == 0) coinc_read(4'b1010); else tick(4);
            if (k == 0) begin
                for (int g = 0; g < 4; g++)
                    check($sformatf("miso_byte%0d[%0d]", bi, g), {24'd0, cap[g]}, {24'd0, exp_tx});
                m_byte_done(mosi_bytes[bi]);
                m_load(exp_tx);
            end
        end
        if (end_cs) begin
            cs_n = 1'b1;
            mosi_h = 2'b00;
            tick(5);
            check("miso_idle", {28'd0, miso_v}, 32'd0);
        end
    endtask

    initial begin
        int cnt [4];
        logic [31:0] rd0 [4];
        logic [7:0] v;
        int nb;

        n_assert = 0; n_fail = 0;
        resetn = 1'b0; valid_v = 4'h0; addr = 32'd0; wstrb = 4'h0; wdata = 32'd0;
        sclk_p = 2'b10; cs_n = 1'b1; mosi_h = 2'b00;
        m_reset();
        tick(3);
        check("rst_ready", {28'd0, ready_v}, 32'd0);
        check("rst_miso", {28'd0, miso_v}, 32'd0);
        for (int g = 0; g < 4; g++) check($sformatf("rst_rdata[%0d]", g), rdata_v[g], 32'd0);
        resetn = 1'b1;
        tick(2);
        rd_check(32'h4, m_stat(1'b0), "rst_stat");
        rd_check(32'h0, 32'd0, "rst_data");

        // 1: TX 0xA5 out, 0x3C in
        wr_data(8'hA5);
        mosi_bytes[0] = 8'h3C;
        spi_frame(8, 1'b1, 1'b0);
        rd_check(32'h4, m_stat(1'b0), "t1_stat");
        check("t1_stat_const", m_stat(1'b0), 32'h3);
        rd_check(32'h0, {24'd0, m_rx_data}, "t1_data");
        m_rx_valid = 1'b0;

        // 2: two bytes unread -> overrun, then clear
        mosi_bytes[0] = 8'h11; mosi_bytes[1] = 8'h22;
        spi_frame(16, 1'b1, 1'b0);
        rd_check(32'h0, {24'd0, m_rx_data}, "t2_data");
        m_rx_valid = 1'b0;
        rd_check(32'h4, m_stat(1'b0), "t2_stat_ovr");
        bus(32'h4, 4'hF, 32'h4);
        m_overrun = 1'b0;
        rd_check(32'h4, m_stat(1'b0), "t2_stat_clr");

        // 3: empty TX -> zeros on miso
        mosi_bytes[0] = 8'h96;
        spi_frame(8, 1'b1, 1'b0);
        rd_check(32'h4, m_stat(1'b0), "t3_stat");
        rd_check(32'h0, {24'd0, m_rx_data}, "t3_data");
        m_rx_valid = 1'b0;

        // 4: abort after 5 bits, then a clean byte
        mosi_bytes[0] = 8'hFF;
        spi_frame(5, 1'b0, 1'b0);
        rd_check(32'h4, m_stat(1'b1), "t4_stat_busy");
        cs_n = 1'b1; mosi_h = 2'b00;
        tick(5);
        check("t4_miso_idle", {28'd0, miso_v}, 32'd0);
        rd_check(32'h4, m_stat(1'b0), "t4_stat_abort");
        wr_data(8'hC3);
        mosi_bytes[0] = 8'h81;
        spi_frame(8, 1'b1, 1'b0);
        rd_check(32'h0, {24'd0, m_rx_data}, "t4_data");
        m_rx_valid = 1'b0;

        // 5: DATA read coincident with byte completion
        mosi_bytes[0] = 8'h7E;
        spi_frame(8, 1'b1, 1'b1);
        rd_check(32'h4, m_stat(1'b0), "t5_stat");
        rd_check(32'h0, {24'd0, m_rx_data}, "t5_data");
        m_rx_valid = 1'b0;

        // 6: single ready pulse, unmapped registers
        addr = 32'h8; wstrb = 4'h0; valid_v = 4'hF;
        for (int g = 0; g < 4; g++) begin cnt[g] = 0; rd0[g] = 32'hDEAD_BEEF; end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            for (int g = 0; g < 4; g++)
                if (ready_v[g]) begin cnt[g]++; rd0[g] = rdata_v[g]; valid_v[g] = 1'b0; end
        end
        valid_v = 4'h0;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("t6_pulses[%0d]", g), cnt[g], 32'd1);
            check($sformatf("t6_rd8[%0d]", g), rd0[g], 32'd0);
        end
        bus(32'hC, 4'hF, 32'hFFFF_FFFF);
        rd_check(32'h4, m_stat(1'b0), "t6_stat_after_wrC");

        // 6: reset in the middle of a frame
        wr_data(8'h99);
        mosi_bytes[0] = 8'hE7;
        spi_frame(3, 1'b0, 1'b0);
        resetn = 1'b0;
        tick(2);
        check("t6_rst_miso", {28'd0, miso_v}, 32'd0);
        check("t6_rst_ready", {28'd0, ready_v}, 32'd0);
        cs_n = 1'b1; mosi_h = 2'b00;
        tick(1);
        resetn = 1'b1;
        m_reset();
        tick(4);
        rd_check(32'h4, m_stat(1'b0), "t6_rst_stat");
        rd_check(32'h0, 32'd0, "t6_rst_data");

        // randomized traffic against the model
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = 8'($urandom_range(0, 255));
                wr_data(v);
            end
            nb = $urandom_range(1, 2);
            for (int j = 0; j < nb; j++) mosi_bytes[j] = 8'($urandom_range(0, 255));
            spi_frame(nb * 8, 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                rd_check(32'h0, {24'd0, m_rx_data}, "rnd_data");
                m_rx_valid = 1'b0;
            end else begin
                rd_check(32'h4, m_stat(1'b0), "rnd_stat");
            end
            if (m_overrun && ($urandom_range(0, 1) == 1)) begin
                bus(32'h4, 4'hF, 32'h4);
                m_overrun = 1'b0;
            end
        end
        rd_check(32'h4, m_stat(1'b0), "final_stat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
